// File: rtl/mux_2to1_interleave.sv
// Interleaves two valid/ready lanes onto one registered output by alternating the drain lane every cycle.
// A word appears one or two edges after it is accepted. A lane stalls (ready low) only while its one-word holding register is full and the other lane owns the drain slot.
module mux_2to1_interleave #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data_in0,
   input  logic             valid_in0,
   output logic             ready_in0,
   input  logic [WIDTH-1:0] data_in1,
   input  logic             valid_in1,
   output logic             ready_in1,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             lane_out
);

   logic             sel;
   logic [1:0]       pend;
   logic [WIDTH-1:0] hold0;
   logic [WIDTH-1:0] hold1;
   logic             accept0;
   logic             accept1;
   logic             drain0;
   logic             drain1;

   // A full holding register can still take a word on its own drain edge.
   assign ready_in0 = !pend[0] || !sel;
   assign ready_in1 = !pend[1] || sel;

   assign accept0 = valid_in0 && ready_in0;
   assign accept1 = valid_in1 && ready_in1;
   assign drain0  = pend[0] && !sel;
   assign drain1  = pend[1] && sel;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         sel <= 1'b0;
      end else begin
         sel <= ~sel;
      end
   end

   // Loading a new word wins over clearing, so a same-edge drain and refill keeps pend set.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         pend  <= 2'b00;
         hold0 <= '0;
         hold1 <= '0;
      end else begin
         if (accept0) begin
            hold0   <= data_in0;
            pend[0] <= 1'b1;
         end else if (drain0) begin
            pend[0] <= 1'b0;
         end
         if (accept1) begin
            hold1   <= data_in1;
            pend[1] <= 1'b1;
         end else if (drain1) begin
            pend[1] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         lane_out  <= 1'b0;
      end else if (drain0) begin
         data_out  <= hold0;
         valid_out <= 1'b1;
         lane_out  <= 1'b0;
      end else if (drain1) begin
         data_out  <= hold1;
         valid_out <= 1'b1;
         lane_out  <= 1'b1;
      end else begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_2to1_interleave.sv
// Self-checking bench: per-lane scoreboard queues model the holding registers and predict every output edge.
module tb_mux_2to1_interleave;

   logic       clk;
   logic       reset_L;
   logic [7:0] data_in0;
   logic       valid_in0;
   logic       ready_in0;
   logic [7:0] data_in1;
   logic       valid_in1;
   logic       ready_in1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       lane_out;

   int n_cmp;
   int n_bad;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] seen[$];
   logic       m_sel;
   logic [7:0] last_dat;
   logic       last_lane;
   int         run;
   int         max_run;

   mux_2to1_interleave #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .data_in0  (data_in0),
      .valid_in0 (valid_in0),
      .ready_in0 (ready_in0),
      .data_in1  (data_in1),
      .valid_in1 (valid_in1),
      .ready_in1 (ready_in1),
      .data_out  (data_out),
      .valid_out (valid_out),
      .lane_out  (lane_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called with clk low; drives one cycle of stimulus and checks the following edge.
   task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                       output logic r0, output logic r1);
      logic       e_rdy0;
      logic       e_rdy1;
      logic       a0;
      logic       a1;
      logic       e_vld;
      logic [7:0] e_dat;
      logic       e_lane;
      valid_in0 = v0;
      data_in0  = d0;
      valid_in1 = v1;
      data_in1  = d1;
      #1;
      e_rdy0 = (q0.size() == 0) || (m_sel == 1'b0);
      e_rdy1 = (q1.size() == 0) || (m_sel == 1'b1);
      r0 = ready_in0;
      r1 = ready_in1;
      chk("ready_in0", {31'd0, ready_in0}, {31'd0, e_rdy0});
      chk("ready_in1", {31'd0, ready_in1}, {31'd0, e_rdy1});
      a0 = v0 && e_rdy0;
      a1 = v1 && e_rdy1;
      @(posedge clk);
      e_vld  = 1'b0;
      e_dat  = last_dat;
      e_lane = last_lane;
      if (m_sel == 1'b0 && q0.size() > 0) begin
         e_vld  = 1'b1;
         e_dat  = q0.pop_front();
         e_lane = 1'b0;
      end else if (m_sel == 1'b1 && q1.size() > 0) begin
         e_vld  = 1'b1;
         e_dat  = q1.pop_front();
         e_lane = 1'b1;
      end
      if (a0) q0.push_back(d0);
      if (a1) q1.push_back(d1);
      m_sel = ~m_sel;
      #1;
      chk("valid_out", {31'd0, valid_out}, {31'd0, e_vld});
      chk("data_out", {24'd0, data_out}, {24'd0, e_dat});
      chk("lane_out", {31'd0, lane_out}, {31'd0, e_lane});
      last_dat  = e_dat;
      last_lane = e_lane;
      if (valid_out) begin
         seen.push_back(data_out);
         run++;
      end else begin
         run = 0;
      end
      if (run > max_run) max_run = run;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      logic r0;
      logic r1;
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, r0, r1);
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_sel     = 1'b0;
      last_dat  = 8'h00;
      last_lane = 1'b0;
   endtask

   // Reset is held across two edges with both lanes offering words that must not be taken.
   task automatic do_reset();
      reset_L   = 1'b0;
      valid_in0 = 1'b1;
      data_in0  = 8'hEE;
      valid_in1 = 1'b1;
      data_in1  = 8'hDD;
      model_reset();
      #1;
      chk("rst_ready0", {31'd0, ready_in0}, 32'd1);
      chk("rst_ready1", {31'd0, ready_in1}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_data", {24'd0, data_out}, 32'd0);
      chk("rst_lane", {31'd0, lane_out}, 32'd0);
      valid_in0 = 1'b0;
      valid_in1 = 1'b0;
      reset_L   = 1'b1;
   endtask

   initial begin
      logic       r0;
      logic       r1;
      logic [7:0] s0 [3];
      logic [7:0] s1 [3];
      logic [7:0] exp_seq [6];
      int         i0;
      int         i1;
      int         cyc;
      n_cmp   = 0;
      n_bad   = 0;
      run     = 0;
      max_run = 0;
      reset_L   = 1'b0;
      data_in0  = 8'h00;
      data_in1  = 8'h00;
      valid_in0 = 1'b0;
      valid_in1 = 1'b0;
      model_reset();
      @(negedge clk);

      // Idle after reset: nothing ever comes out.
      do_reset();
      idle(6);

      // Single lane-1 word on the first edge after reset.
      do_reset();
      step(1'b0, 8'h00, 1'b1, 8'hA5, r0, r1);
      seen.delete();
      step(1'b0, 8'h00, 1'b0, 8'h00, r0, r1);
      chk("single_out", {24'd0, data_out}, 32'h0000_00A5);
      idle(1);
      chk("single_count", seen.size(), 32'd1);

      // Two streams, each source advancing only on ready.
      s0 = '{8'h10, 8'h11, 8'h12};
      s1 = '{8'h20, 8'h21, 8'h22};
      exp_seq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
      if (m_sel == 1'b0) idle(1);
      seen.delete();
      max_run = 0;
      i0  = 0;
      i1  = 0;
      cyc = 0;
      while (cyc < 40 && !(i0 == 3 && i1 == 3 && q0.size() == 0 && q1.size() == 0)) begin
         step(i0 < 3, (i0 < 3) ? s0[i0] : 8'h00, i1 < 3, (i1 < 3) ? s1[i1] : 8'h00, r0, r1);
         if (i0 < 3 && r0) i0++;
         if (i1 < 3 && r1) i1++;
         cyc++;
      end
      chk("stream_done", {31'd0, cyc < 40}, 32'd1);
      chk("stream_count", seen.size(), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < seen.size()) chk("stream_order", {24'd0, seen[k]}, {24'd0, exp_seq[k]});
      end
      chk("stream_back_to_back", max_run, 32'd6);

      // Lane 0 full while lane 1 owns the drain slot: second word must wait one cycle.
      idle(2);
      if (m_sel == 1'b1) idle(1);
      seen.delete();
      step(1'b1, 8'h50, 1'b0, 8'h00, r0, r1);
      chk("bp_first_accept", {31'd0, r0}, 32'd1);
      step(1'b1, 8'h51, 1'b0, 8'h00, r0, r1);
      chk("bp_stall", {31'd0, r0}, 32'd0);
      step(1'b1, 8'h51, 1'b0, 8'h00, r0, r1);
      chk("bp_retry_accept", {31'd0, r0}, 32'd1);
      idle(3);
      chk("bp_count", seen.size(), 32'd2);
      if (seen.size() == 2) begin
         chk("bp_word0", {24'd0, seen[0]}, 32'h50);
         chk("bp_word1", {24'd0, seen[1]}, 32'h51);
      end

      // Reset between edges with both holding registers loaded.
      step(1'b1, 8'h33, 1'b1, 8'h44, r0, r1);
      #2;
      reset_L = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, valid_out}, 32'd0);
      chk("midrst_data", {24'd0, data_out}, 32'd0);
      @(negedge clk);
      do_reset();
      seen.delete();
      idle(6);
      chk("midrst_no_words", seen.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux_2to1_interleave.md
MUX_2TO1_INTERLEAVE -- requirements
Module: mux_2to1_interleave

Interface
REQ-001 Parameter: WIDTH, default 8, data lane width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_L  input  1  reset; asynchronous, active-low.
REQ-004 data_in0  input  WIDTH  lane-0 input word.
REQ-005 valid_in0  input  1  lane-0 word present this cycle.
REQ-006 ready_in0  output  1  lane-0 may accept a word this cycle (combinational).
REQ-007 data_in1  input  WIDTH  lane-1 input word.
REQ-008 valid_in1  input  1  lane-1 word present this cycle.
REQ-009 ready_in1  output  1  lane-1 may accept a word this cycle (combinational).
REQ-010 data_out  output  WIDTH  interleaved output word, registered.
REQ-011 valid_out  output  1  data_out carries a new word this cycle, registered.
REQ-012 lane_out  output  1  source lane of the current data_out, registered.

Function
REQ-013 Internal selector sel SHALL toggle on every rising clk edge while reset_L=1; the value before the edge is the drain lane for that edge.
REQ-014 Each lane X SHALL have a one-word holding register holdX with a pending flag pendX.
REQ-015 ready_inX SHALL equal (!pendX) | (sel==X).
REQ-016 Accept: a word transfers on an edge where valid_inX & ready_inX = 1; holdX <= data_inX and pendX <= 1.
REQ-017 If valid_inX=1 and ready_inX=0, the block SHALL ignore the word; the source holds it.
REQ-018 Drain: on each edge, if pend[sel]=1, then data_out <= hold[sel], valid_out <= 1, lane_out <= sel, pend[sel] cleared.
REQ-019 If pend[sel]=0 at an edge: valid_out <= 0; data_out and lane_out hold their previous values.
REQ-020 Same-lane drain and accept on one edge: the drained word is the old hold value; the new word is loaded and pendX=1 after the edge. Set takes priority over clear.
REQ-021 The non-selected lane SHALL never drain; its pending word waits for the next edge.
REQ-022 Latency: a word accepted at edge k SHALL appear on data_out after edge k+1 if sel==X at edge k+1, otherwise after edge k+2.
REQ-023 Words SHALL never be dropped or duplicated; per-lane order SHALL be preserved.
REQ-024 Throughput: each lane sustains one word per 2 cycles; both lanes together sustain one word per cycle.
REQ-025 valid_out SHALL be high for exactly one cycle per drained word.

Reset
REQ-026 reset_L=0 SHALL immediately, independent of clk, force:
- sel=0
- pend0=pend1=0
- hold0=hold1=0
- data_out=0
- valid_out=0
- lane_out=0
REQ-027 During reset, ready_in0=1 and ready_in1=1, but no word SHALL be accepted.
REQ-028 Reset asserted mid-operation SHALL discard all pending words.
REQ-029 The first edge after deassertion SHALL use sel=0 as the drain lane.

Verification
REQ-030 Reset, then hold valid_in0=valid_in1=0 for 6 cycles -> valid_out=0 throughout; data_out=0; lane_out=0.
REQ-031 Single word on lane 1:
- stimulus: data_in1=8'hA5, valid_in1=1 for one cycle, accepted at the first edge (sel=0)
- required: after the next edge, data_out=8'hA5, valid_out=1, lane_out=1
- required: valid_out=0 on the following cycle
REQ-032 Continuous streams:
- stimulus: lane 0 sends 8'h10, 8'h11, 8'h12; lane 1 sends 8'h20, 8'h21, 8'h22, each source advancing only on ready
- required: data_out sequence is 10, 20, 11, 21, 12, 22, with valid_out high on consecutive cycles once streaming
REQ-033 Backpressure:
- stimulus: lane 0 holds valid_in0=1 while pend0=1 and sel=1
- required: ready_in0=0 and the word is not accepted
- required: the word is accepted on the next cycle, and no word is lost or duplicated
REQ-034 Mid-operation reset:
- stimulus: load 8'h33 into lane 0 and 8'h44 into lane 1, then assert reset_L=0 between clock edges
- required: valid_out=0 and data_out=0 immediately
- required: neither 8'h33 nor 8'h44 ever appears after reset is released
